counter_burst_sched: RTL and testbench

- Scheduler that shares the dual 64-bit event counter block (channel 0 counts every enable, channel 1 counts every 4th enable) between two requesters.
- Each requester asks for a burst of N count-enable cycles on a chosen channel.
- The block arbitrates round-robin and drives the counter's En/Slt/Reset inputs cycle by cycle.
- It also sequences a one-cycle counter clear on request, and supports a global hold that stalls a burst in progress.

---
 rtl/counter_burst_sched_if.sv | 33 +++
 rtl/counter_burst_sched.sv | 132 +++++++++++++
 tb/tb_counter_burst_sched.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_burst_sched_if.sv
// Bundle of requester, control and counter-drive signals for counter_burst_sched.
// master = requester/environment side, slave = the scheduler.
interface counter_burst_sched_if #(
    parameter int LEN_W = 16
);
    logic             Clr;
    logic             Hold;
    logic             Req0;
    logic             Slt0;
    logic [LEN_W-1:0] Len0;
    logic             Req1;
    logic             Slt1;
    logic [LEN_W-1:0] Len1;
    logic             Gnt0;
    logic             Gnt1;
    logic             Done0;
    logic             Done1;
    logic             Busy;
    logic [LEN_W-1:0] Remain;
    logic             Cnt_En;
    logic             Cnt_Slt;
    logic             Cnt_Reset;

    modport master (
        output Clr, Hold, Req0, Slt0, Len0, Req1, Slt1, Len1,
        input  Gnt0, Gnt1, Done0, Done1, Busy, Remain, Cnt_En, Cnt_Slt, Cnt_Reset
    );

    modport slave (
        input  Clr, Hold, Req0, Slt0, Len0, Req1, Slt1, Len1,
        output Gnt0, Gnt1, Done0, Done1, Busy, Remain, Cnt_En, Cnt_Slt, Cnt_Reset
    );
endinterface

// File: rtl/counter_burst_sched.sv
// Round-robin burst scheduler in front of the dual 64-bit event counter.
// Two requesters each ask for N enable cycles on a chosen channel; the block
// also sequences a one-cycle counter clear and honours a global hold.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting; Clr wins over requests, else round-robin grant
// CLEAR | Cnt_Reset high for one cycle, then back to IDLE
// RUN   | Cnt_En = ~Hold, Remain counts down on every unheld edge
// DONE  | Done pulse to owner, pointer moves to the other requester
module counter_burst_sched #(
    parameter int LEN_W = 16
) (
    input  logic                  Clk,
    input  logic                  Reset,
    counter_burst_sched_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_ZERO = '0;

    state_t           state_q,  state_d;
    logic             ptr_q,    ptr_d;
    logic             owner_q,  owner_d;
    logic             slt_q,    slt_d;
    logic [LEN_W-1:0] remain_q, remain_d;
    logic [1:0]       gnt_q,    gnt_d;

    logic             win;
    logic [LEN_W-1:0] win_len;

    logic             busy;
    logic             cnt_en;
    logic             cnt_reset;
    logic [1:0]       done;

    // State and datapath registers; reset aborts any burst without a Done.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= S_IDLE;
            ptr_q    <= 1'b0;
            owner_q  <= 1'b0;
            slt_q    <= 1'b0;
            remain_q <= '0;
            gnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            slt_q    <= slt_d;
            remain_q <= remain_d;
            gnt_q    <= gnt_d;
        end
    end

    // Next state, arbitration and burst bookkeeping.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        slt_d    = slt_q;
        remain_d = remain_q;
        gnt_d    = '0;
        win      = 1'b0;
        win_len  = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.Clr) begin
                    state_d = S_CLEAR;
                end else if (bus.Req0 || bus.Req1) begin
                    // Contention goes to the pointer; a lone request simply wins.
                    win      = (bus.Req0 && bus.Req1) ? ptr_q : bus.Req1;
                    win_len  = win ? bus.Len1 : bus.Len0;
                    owner_d  = win;
                    slt_d    = win ? bus.Slt1 : bus.Slt0;
                    remain_d = win_len;
                    gnt_d[win] = 1'b1;
                    // A zero-length burst skips RUN so Remain can never underflow.
                    state_d  = (win_len != LEN_ZERO) ? S_RUN : S_DONE;
                end
            end
            S_CLEAR: begin
                state_d = S_IDLE;
            end
            S_RUN: begin
                if (!bus.Hold) begin
                    remain_d = remain_q - LEN_ONE;
                    if (remain_q == LEN_ONE) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                ptr_d   = ~owner_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore outputs plus the Hold-gated enable.
    always_comb begin
        busy      = (state_q != S_IDLE);
        cnt_en    = (state_q == S_RUN) && !bus.Hold;
        cnt_reset = (state_q == S_CLEAR);
        done      = '0;
        if (state_q == S_DONE) begin
            done[owner_q] = 1'b1;
        end
    end

    assign bus.Gnt0      = gnt_q[0];
    assign bus.Gnt1      = gnt_q[1];
    assign bus.Done0     = done[0];
    assign bus.Done1     = done[1];
    assign bus.Busy      = busy;
    assign bus.Remain    = remain_q;
    assign bus.Cnt_En    = cnt_en;
    assign bus.Cnt_Slt   = slt_q;
    assign bus.Cnt_Reset = cnt_reset;

endmodule

// File: tb/tb_counter_burst_sched.sv
// Directed bench for counter_burst_sched: a transaction-level model checked
// against the DUT every cycle, plus literal expectations per scenario.
module tb_counter_burst_sched;

    localparam int LEN_W = 16;

    logic Clk = 1'b0;
    logic Reset;

    counter_burst_sched_if #(.LEN_W(LEN_W)) bus ();

    counter_burst_sched #(.LEN_W(LEN_W)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    int tests = 0;
    int fails = 0;

    // Model: what the scheduler owes right now, expressed as activities.
    int m_owed;
    bit m_owner, m_slt, m_ptr;
    bit m_clearing, m_running, m_finishing;
    bit [1:0] m_gnt;

    // Observed totals and a simple model of the counter block.
    int en0_total = 0, en1_total = 0;
    int done_total [2];
    int out0 = 0, out1 = 0, presc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owed = 0; m_owner = 0; m_slt = 0; m_ptr = 0;
        m_clearing = 0; m_running = 0; m_finishing = 0; m_gnt = '0;
    endtask

    // Compare just before each rising edge, then advance the model on the edge.
    always begin
        @(negedge Clk);
        #4;
        if (!Reset) model_reset();
        check("busy",      bus.Busy,      m_clearing | m_running | m_finishing);
        check("cnt_reset", bus.Cnt_Reset, m_clearing);
        check("cnt_en",    bus.Cnt_En,    m_running & !bus.Hold);
        check("cnt_slt",   bus.Cnt_Slt,   m_slt);
        check("remain",    bus.Remain,    m_owed);
        check("gnt0",      bus.Gnt0,      m_gnt[0]);
        check("gnt1",      bus.Gnt1,      m_gnt[1]);
        check("done0",     bus.Done0,     m_finishing && !m_owner);
        check("done1",     bus.Done1,     m_finishing && m_owner);
        if (bus.Done0) done_total[0]++;
        if (bus.Done1) done_total[1]++;
        if (bus.Cnt_Reset) begin
            out0 = 0; out1 = 0; presc = 0;
        end else if (bus.Cnt_En) begin
            if (!bus.Cnt_Slt) begin
                en0_total++; out0++;
            end else begin
                en1_total++;
                if (presc == 3) begin presc = 0; out1++; end
                else presc++;
            end
        end
        @(posedge Clk);
        if (Reset) begin
            m_gnt = '0;
            if (m_clearing) begin
                m_clearing = 0;
            end else if (m_running) begin
                if (!bus.Hold) begin
                    m_owed--;
                    if (m_owed == 0) begin m_running = 0; m_finishing = 1; end
                end
            end else if (m_finishing) begin
                m_finishing = 0;
                m_ptr = !m_owner;
            end else if (bus.Clr) begin
                m_clearing = 1;
            end else if (bus.Req0 || bus.Req1) begin
                bit w;
                w = (bus.Req0 && bus.Req1) ? m_ptr : bus.Req1;
                m_owner = w;
                m_slt   = w ? bus.Slt1 : bus.Slt0;
                m_owed  = w ? int'(bus.Len1) : int'(bus.Len0);
                m_gnt[w] = 1'b1;
                if (m_owed > 0) m_running = 1; else m_finishing = 1;
            end
        end
    end

    task automatic wait_gnt_any(input int budget, output int who, output int waited);
        who = -1; waited = 0;
        while (who < 0 && waited < budget) begin
            @(negedge Clk);
            waited++;
            if (bus.Gnt0) who = 0;
            else if (bus.Gnt1) who = 1;
        end
        if (who < 0) check("gnt_timeout", 0, 1);
    endtask

    task automatic wait_done(input int who, input int budget, output int waited);
        waited = 0;
        while (!(who == 1 ? bus.Done1 : bus.Done0) && waited < budget) begin
            @(negedge Clk);
            waited++;
        end
        if (!(who == 1 ? bus.Done1 : bus.Done0)) check("done_timeout", 0, 1);
    endtask

    task automatic drop_req(input int who);
        if (who == 0) bus.Req0 = 1'b0;
        else if (who == 1) bus.Req1 = 1'b0;
    endtask

    // Waits for the next grant, checks its winner and that Done follows after run_len cycles.
    task automatic serve(input int exp_who, input int run_len, input string tag);
        int w, n, d;
        wait_gnt_any(50, w, n);
        check({tag, "_winner"}, w, exp_who);
        if (w >= 0) begin
            drop_req(w);
            wait_done(w, 100, d);
            check({tag, "_run"}, d, run_len);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, n, d, e0, e1, o1, dt;
        done_total[0] = 0; done_total[1] = 0;
        Reset = 1'b0;
        bus.Clr = 0; bus.Hold = 0;
        bus.Req0 = 0; bus.Slt0 = 0; bus.Len0 = '0;
        bus.Req1 = 0; bus.Slt1 = 0; bus.Len1 = '0;

        repeat (3) @(negedge Clk);
        check("rst_busy", bus.Busy, 0);
        check("rst_remain", bus.Remain, 0);
        check("rst_outs", {bus.Gnt0, bus.Gnt1, bus.Done0, bus.Done1,
                           bus.Cnt_En, bus.Cnt_Reset, bus.Cnt_Slt}, 0);
        Reset = 1'b1;

        // Single burst of 5 on channel 0.
        @(negedge Clk);
        bus.Req0 = 1; bus.Slt0 = 0; bus.Len0 = 16'd5;
        e0 = en0_total;
        wait_gnt_any(50, w, n);
        check("t1_winner", w, 0);
        check("t1_gnt_latency", n, 1);
        drop_req(0);
        wait_done(0, 50, d);
        check("t1_run_cycles", d, 5);
        check("t1_remain_end", bus.Remain, 0);
        check("t1_en_count", en0_total - e0, 5);
        check("t1_out0", out0, 5);

        // Round-robin from a fresh reset.
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        bus.Len0 = 16'd3; bus.Len1 = 16'd3; bus.Slt1 = 1;
        bus.Req0 = 1; bus.Req1 = 1;
        serve(0, 3, "t2a");
        serve(1, 3, "t2b");
        bus.Req0 = 1; bus.Req1 = 1;
        serve(0, 3, "t2c");
        bus.Req0 = 1;
        serve(1, 3, "t2d");
        serve(0, 3, "t2e");

        // Clear has priority over a simultaneous request.
        @(negedge Clk);
        bus.Len0 = 16'd2; bus.Req0 = 1; bus.Clr = 1;
        n = 0;
        while (!bus.Cnt_Reset && n < 10) begin @(negedge Clk); n++; end
        check("t4_clr_latency", n, 1);
        check("t4_no_gnt_in_clear", bus.Gnt0, 0);
        bus.Clr = 0;
        wait_gnt_any(50, w, n);
        check("t4_winner", w, 0);
        check("t4_gnt_after_clear", n, 2);
        check("t4_out0_cleared", out0, 0);
        check("t4_out1_cleared", out1, 0);
        drop_req(0);
        wait_done(0, 50, d);
        check("t4_run_cycles", d, 2);

        // Channel-1 burst of 8 with Hold over RUN cycles 2..4.
        bus.Req1 = 1; bus.Slt1 = 1; bus.Len1 = 16'd8;
        e1 = en1_total; o1 = out1;
        wait_gnt_any(50, w, n);
        check("t3_winner", w, 1);
        drop_req(1);
        @(negedge Clk); bus.Hold = 1;
        @(negedge Clk);
        @(negedge Clk);
        check("t3_remain_frozen", bus.Remain, 7);
        @(negedge Clk); bus.Hold = 0;
        wait_done(1, 50, d);
        check("t3_done_after_hold", d, 7);
        check("t3_en_count", en1_total - e1, 8);
        check("t3_out1_adv", out1 - o1, 2);

        // Zero-length burst: Gnt and Done together, no enables.
        bus.Req0 = 1; bus.Len0 = '0;
        e0 = en0_total;
        wait_gnt_any(50, w, n);
        check("t5_winner", w, 0);
        check("t5_gnt_latency", n, 2);
        check("t5_done_with_gnt", bus.Done0, 1);
        drop_req(0);
        @(negedge Clk);
        check("t5_no_enable", en0_total - e0, 0);
        check("t5_idle", bus.Busy, 0);

        // Reset in the middle of a burst.
        bus.Req0 = 1; bus.Len0 = 16'd10;
        wait_gnt_any(50, w, n);
        check("t6_winner", w, 0);
        drop_req(0);
        n = 0;
        while (bus.Remain != 16'd4 && n < 20) begin @(negedge Clk); n++; end
        check("t6_reach_remain4", bus.Remain, 4);
        dt = done_total[0];
        Reset = 1'b0;
        #1;
        check("t6_busy_now", bus.Busy, 0);
        check("t6_remain_now", bus.Remain, 0);
        check("t6_en_now", bus.Cnt_En, 0);
        repeat (3) @(negedge Clk);
        check("t6_no_done", done_total[0] - dt, 0);
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        check("t6_idle_after", bus.Busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
